// File: rtl/vector_format_convert_pkg.sv
// Shared definitions for the vector Q-format converter: round-mode encodings
// and the helpers that derive internal widths from the element formats.
package vector_format_convert_pkg;

    typedef enum logic [1:0] {
        ROUND_FLOOR     = 2'd0,
        ROUND_HALF_UP   = 2'd1,
        ROUND_HALF_EVEN = 2'd2,
        ROUND_HALF_AWAY = 2'd3
    } round_mode_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Two spare bits above the widest operand keep round-up and left shifts from wrapping.
    function automatic int work_width(input int in_width, input int out_width, input int shift);
        int left;
        left = (shift < 0) ? -shift : 0;
        return max_int(in_width + left, out_width) + 2;
    endfunction

endpackage

// File: rtl/vector_format_convert_round_sat.sv
// Single-element shift, round, symmetric clamp and saturation flag.
// Purely combinational; the top instantiates one per vector element.
module vector_round_sat
    import vector_format_convert_pkg::*;
#(
    parameter int IN_DATA_WIDTH      = 12,
    parameter int IN_FRACTION_WIDTH  = 6,
    parameter int OUT_DATA_WIDTH     = 8,
    parameter int OUT_FRACTION_WIDTH = 4
) (
    input  logic [IN_DATA_WIDTH-1:0]  data_in,
    input  round_mode_e               round_mode,
    output logic [OUT_DATA_WIDTH-1:0] data_out,
    output logic                      sat_flag
);

    localparam int SHIFT      = IN_FRACTION_WIDTH - OUT_FRACTION_WIDTH;
    localparam int WORK_WIDTH = work_width(IN_DATA_WIDTH, OUT_DATA_WIDTH, SHIFT);
    localparam logic signed [WORK_WIDTH-1:0] OUT_MAX = WORK_WIDTH'((1 << (OUT_DATA_WIDTH - 1)) - 1);
    localparam logic signed [WORK_WIDTH-1:0] OUT_MIN = -OUT_MAX;

    logic signed [WORK_WIDTH-1:0] extended;
    logic signed [WORK_WIDTH-1:0] shifted;
    logic signed [WORK_WIDTH-1:0] rounded;
    logic signed [WORK_WIDTH-1:0] clamped;
    logic                         round_inc;

    assign extended = {{(WORK_WIDTH - IN_DATA_WIDTH){data_in[IN_DATA_WIDTH-1]}}, data_in};

    if (SHIFT <= 0) begin : g_widen
        assign shifted   = extended <<< (-SHIFT);
        assign round_inc = 1'b0;
    end else begin : g_narrow
        logic guard;
        logic sticky;
        logic lsb;
        logic sign;

        assign shifted = extended >>> SHIFT;
        assign guard   = extended[SHIFT-1];
        assign lsb     = extended[SHIFT];
        assign sign    = extended[WORK_WIDTH-1];

        if (SHIFT >= 2) begin : g_sticky
            assign sticky = |extended[SHIFT-2:0];
        end else begin : g_no_sticky
            assign sticky = 1'b0;
        end

        always_comb begin
            // NOTE: every output of a combinational block gets a default first so no latch is inferred.
            round_inc = 1'b0;
            case (round_mode)
                ROUND_FLOOR:     round_inc = 1'b0;
                ROUND_HALF_UP:   round_inc = guard;
                ROUND_HALF_EVEN: round_inc = guard & (sticky | lsb);
                ROUND_HALF_AWAY: round_inc = guard & (sticky | ~sign);
                default:         round_inc = 1'b0;
            endcase
        end
    end

    always_comb begin
        rounded  = shifted + {{(WORK_WIDTH - 1){1'b0}}, round_inc};
        clamped  = rounded;
        sat_flag = 1'b0;
        if (rounded > OUT_MAX) begin
            clamped  = OUT_MAX;
            sat_flag = 1'b1;
        end else if (rounded < OUT_MIN) begin
            clamped  = OUT_MIN;
            sat_flag = 1'b1;
        end
        data_out = OUT_DATA_WIDTH'(clamped);
    end

endmodule

// File: rtl/vector_format_convert.sv
// Two-stage valid/ready pipeline converting a vector of signed fixed-point
// elements between Q-formats, with per-element saturation flags and a saturating event counter.
module vector_format_convert
    import vector_format_convert_pkg::*;
#(
    parameter int TAG_WIDTH          = 32,
    parameter int BLOCKLENGTH        = 1,
    parameter int IN_DATA_WIDTH      = 12,
    parameter int IN_FRACTION_WIDTH  = 6,
    parameter int OUT_DATA_WIDTH     = 8,
    parameter int OUT_FRACTION_WIDTH = 4,
    parameter int COUNT_WIDTH        = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  valid_in,
    output logic                                  busy,
    input  logic [TAG_WIDTH-1:0]                  tag_in,
    input  logic [IN_DATA_WIDTH*BLOCKLENGTH-1:0]  data_in,
    input  logic [1:0]                            round_mode,
    input  logic                                  ready_in,
    output logic                                  valid_out,
    output logic [TAG_WIDTH-1:0]                  tag_out,
    output logic [OUT_DATA_WIDTH*BLOCKLENGTH-1:0] data_out,
    output logic [BLOCKLENGTH-1:0]                sat_flags,
    input  logic                                  clear_count,
    output logic [COUNT_WIDTH-1:0]                sat_count
);

    localparam int IN_BUS_WIDTH  = IN_DATA_WIDTH * BLOCKLENGTH;
    localparam int OUT_BUS_WIDTH = OUT_DATA_WIDTH * BLOCKLENGTH;

    logic                     s1_valid_q, s1_valid_d;
    logic [IN_BUS_WIDTH-1:0]  s1_data_q, s1_data_d;
    logic [TAG_WIDTH-1:0]     s1_tag_q, s1_tag_d;
    round_mode_e              s1_mode_q, s1_mode_d;

    logic                     s2_valid_q, s2_valid_d;
    logic [OUT_BUS_WIDTH-1:0] s2_data_q, s2_data_d;
    logic [TAG_WIDTH-1:0]     s2_tag_q, s2_tag_d;
    logic [BLOCKLENGTH-1:0]   s2_flags_q, s2_flags_d;

    logic [COUNT_WIDTH-1:0]   sat_count_q, sat_count_d;

    logic [OUT_BUS_WIDTH-1:0] conv_data;
    logic [BLOCKLENGTH-1:0]   conv_flags;
    logic                     s2_load;
    logic                     s1_load;
    logic                     accept;
    logic                     count_event;

    for (genvar j = 0; j < BLOCKLENGTH; j++) begin : g_elem
        vector_round_sat #(
            .IN_DATA_WIDTH      (IN_DATA_WIDTH),
            .IN_FRACTION_WIDTH  (IN_FRACTION_WIDTH),
            .OUT_DATA_WIDTH     (OUT_DATA_WIDTH),
            .OUT_FRACTION_WIDTH (OUT_FRACTION_WIDTH)
        ) u_round_sat (
            .data_in    (s1_data_q[j*IN_DATA_WIDTH +: IN_DATA_WIDTH]),
            .round_mode (s1_mode_q),
            .data_out   (conv_data[j*OUT_DATA_WIDTH +: OUT_DATA_WIDTH]),
            .sat_flag   (conv_flags[j])
        );
    end

    // A stage advances when it is empty or its successor is taking its beat, so bubbles collapse.
    assign s2_load     = ~s2_valid_q | ready_in;
    assign s1_load     = ~s1_valid_q | s2_load;
    assign busy        = s1_valid_q & ~s2_load;
    assign accept      = valid_in & ~busy;
    assign count_event = s2_valid_q & ready_in & (|s2_flags_q);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_tag_d   = s1_tag_q;
        s1_mode_d  = s1_mode_q;
        if (s1_load) begin
            s1_valid_d = accept;
        end
        if (accept) begin
            s1_data_d = data_in;
            s1_tag_d  = tag_in;
            s1_mode_d = round_mode_e'(round_mode);
        end

        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_tag_d   = s2_tag_q;
        s2_flags_d = s2_flags_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d  = conv_data;
                s2_tag_d   = s1_tag_q;
                s2_flags_d = conv_flags;
            end
        end

        sat_count_d = sat_count_q;
        if (clear_count) begin
            sat_count_d = '0;
        end else if (count_event && (sat_count_q != {COUNT_WIDTH{1'b1}})) begin
            sat_count_d = sat_count_q + COUNT_WIDTH'(1);
        end
    end

    // NOTE: the data registers are reset as well as the valid bits because the outputs must read 0 out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_tag_q    <= '0;
            s1_mode_q   <= ROUND_FLOOR;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_tag_q    <= '0;
            s2_flags_q  <= '0;
            sat_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_tag_q    <= s1_tag_d;
            s1_mode_q   <= s1_mode_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_tag_q    <= s2_tag_d;
            s2_flags_q  <= s2_flags_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign valid_out = s2_valid_q;
    assign tag_out   = s2_tag_q;
    assign data_out  = s2_data_q;
    assign sat_flags = s2_flags_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_vector_format_convert.sv
// Scoreboard bench for vector_format_convert (BLOCKLENGTH=2, default formats),
// with a second COUNT_WIDTH=2 instance sharing the stimulus for counter saturation.
module tb_vector_format_convert;

    localparam int TW = 32;
    localparam int BL = 2;

    typedef struct {
        logic [TW-1:0] tag;
        logic [15:0]   data;
        logic [1:0]    flags;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid_in = 1'b0;
    logic [TW-1:0] tag_in = '0;
    logic [23:0]   data_in = '0;
    logic [1:0]    round_mode = 2'd0;
    logic          ready_in = 1'b1;
    logic          clear_count = 1'b0;

    logic          busy, valid_out;
    logic [TW-1:0] tag_out;
    logic [15:0]   data_out;
    logic [1:0]    sat_flags;
    logic [15:0]   sat_count;

    logic          busy_c, valid_out_c;
    logic [TW-1:0] tag_out_c;
    logic [15:0]   data_out_c;
    logic [1:0]    sat_flags_c;
    logic [1:0]    sat_count_c;

    int checks = 0;
    int errors = 0;
    int delivered = 0;
    beat_t sb_q[$];

    always #5 clk = ~clk;

    vector_format_convert #(.TAG_WIDTH(TW), .BLOCKLENGTH(BL)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .busy(busy),
        .tag_in(tag_in), .data_in(data_in), .round_mode(round_mode),
        .ready_in(ready_in), .valid_out(valid_out), .tag_out(tag_out),
        .data_out(data_out), .sat_flags(sat_flags),
        .clear_count(clear_count), .sat_count(sat_count)
    );

    vector_format_convert #(.TAG_WIDTH(TW), .BLOCKLENGTH(BL), .COUNT_WIDTH(2)) dut_c (
        .clk(clk), .reset(reset), .valid_in(valid_in), .busy(busy_c),
        .tag_in(tag_in), .data_in(data_in), .round_mode(round_mode),
        .ready_in(ready_in), .valid_out(valid_out_c), .tag_out(tag_out_c),
        .data_out(data_out_c), .sat_flags(sat_flags_c),
        .clear_count(clear_count), .sat_count(sat_count_c)
    );

    // Reference: Q5.6 -> Q3.4 via integer quotient/remainder, then symmetric clamp to +-127.
    function automatic logic [8:0] model_elem(input int raw, input int mode);
        int q, rem, r;
        logic flag;
        q   = raw >>> 2;
        rem = raw - q * 4;
        case (mode)
            0:       r = q;
            1:       r = (rem >= 2) ? q + 1 : q;
            2:       r = (rem > 2 || (rem == 2 && (q % 2 != 0))) ? q + 1 : q;
            default: r = (rem > 2 || (rem == 2 && raw >= 0)) ? q + 1 : q;
        endcase
        flag = 1'b0;
        if (r > 127) begin
            r = 127;
            flag = 1'b1;
        end else if (r < -127) begin
            r = -127;
            flag = 1'b1;
        end
        return {flag, r[7:0]};
    endfunction

    function automatic beat_t model_beat(input int tag, input int raw0, input int raw1, input int mode);
        beat_t b;
        logic [8:0] e0, e1;
        e0 = model_elem(raw0, mode);
        e1 = model_elem(raw1, mode);
        b.tag   = TW'(tag);
        b.data  = {e1[7:0], e0[7:0]};
        b.flags = {e1[8], e0[8]};
        return b;
    endfunction

    // Scoreboard monitor: a beat is consumed when valid_out & ready_in hold before the next edge.
    always @(negedge clk) begin
        if (!reset && valid_out && ready_in) begin
            beat_t exp;
            delivered++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: tag=%0d data=%h flags=%b, required no output", tag_out, data_out, sat_flags);
            end else begin
                exp = sb_q.pop_front();
                if ({tag_out, data_out, sat_flags} !== {exp.tag, exp.data, exp.flags}) begin
                    errors++;
                    $display("FAIL beat_compare: got tag=%0d data=%h flags=%b, required tag=%0d data=%h flags=%b",
                             tag_out, data_out, sat_flags, exp.tag, exp.data, exp.flags);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int tag, input int raw0, input int raw1, input int mode);
        bit ok = 1'b0;
        valid_in   = 1'b1;
        tag_in     = TW'(tag);
        data_in    = {12'(raw1), 12'(raw0)};
        round_mode = 2'(mode);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            sb_q.push_back(model_beat(tag, raw0, raw1, mode));
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tag=%0d still busy after 50 cycles, required acceptance", tag);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb_q.size());
        end
        tick();
    endtask

    task automatic pulse_clear();
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({valid_out, busy, tag_out, data_out, sat_flags, sat_count} !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b tag=%0d data=%h flags=%b count=%0d, required all 0",
                     valid_out, busy, tag_out, data_out, sat_flags, sat_count);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_rounding();
        for (int m = 0; m < 4; m++) send_beat(10 + m, 98, -98, m);
        for (int m = 0; m < 4; m++) send_beat(20 + m, 37 + m, -37 - m, m);
        for (int m = 0; m < 4; m++) send_beat(30 + m, 6, -6, m);
        wait_drain();
    endtask

    task automatic test_saturation();
        pulse_clear();
        checks++;
        if (sat_count !== 16'd0) begin
            errors++;
            $display("FAIL count_cleared: got %0d, required 0", sat_count);
        end
        send_beat(40, 640, -2048, 0);
        wait_drain();
        checks++;
        if (sat_count !== 16'd1) begin
            errors++;
            $display("FAIL count_after_sat: got %0d, required 1", sat_count);
        end
    endtask

    task automatic test_bounds();
        send_beat(50, 511, 508, 1);
        send_beat(51, -508, -511, 1);
        send_beat(52, 511, -511, 0);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [TW-1:0] held_tag;
        logic [15:0]   held_data;
        logic [1:0]    held_flags;
        bit            busy_seen = 1'b0;
        bit            held_valid = 1'b0;
        int            start_count;
        start_count = delivered;
        fork
            begin
                for (int t = 1; t <= 6; t++) send_beat(t, 16 * t + 1, -16 * t - 3, t % 4);
            end
            begin
                tick();
                tick();
                tick();
                ready_in = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    if (busy) busy_seen = 1'b1;
                    if (c == 0) begin
                        held_valid = valid_out;
                        held_tag   = tag_out;
                        held_data  = data_out;
                        held_flags = sat_flags;
                    end else begin
                        checks++;
                        if ({valid_out, tag_out, data_out, sat_flags} !== {held_valid, held_tag, held_data, held_flags}) begin
                            errors++;
                            $display("FAIL stall_hold: got v=%b tag=%0d data=%h, required v=%b tag=%0d data=%h",
                                     valid_out, tag_out, data_out, held_valid, held_tag, held_data);
                        end
                    end
                    @(posedge clk);
                    #1;
                end
                ready_in = 1'b1;
            end
        join
        wait_drain();
        checks++;
        if (!busy_seen || !held_valid) begin
            errors++;
            $display("FAIL stall_busy: busy_seen=%b valid_during_stall=%b, required 1 1", busy_seen, held_valid);
        end
        checks++;
        if (delivered - start_count !== 6) begin
            errors++;
            $display("FAIL stream_count: got %0d beats, required 6", delivered - start_count);
        end
    endtask

    task automatic test_counter_sat();
        bit seen = 1'b0;
        pulse_clear();
        for (int i = 0; i < 5; i++) send_beat(60 + i, 640 + i, -700, i % 4);
        wait_drain();
        checks++;
        if (sat_count_c !== 2'd3 || sat_count !== 16'd5) begin
            errors++;
            $display("FAIL count_saturate: got narrow=%0d wide=%0d, required 3 5", sat_count_c, sat_count);
        end
        ready_in = 1'b0;
        send_beat(70, 1000, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid_out) begin
                seen = 1'b1;
                break;
            end
        end
        clear_count = 1'b1;
        ready_in    = 1'b1;
        @(posedge clk);
        #1;
        clear_count = 1'b0;
        checks++;
        if (!seen || sat_count_c !== 2'd0 || sat_count !== 16'd0) begin
            errors++;
            $display("FAIL clear_wins: seen=%b narrow=%0d wide=%0d, required 1 0 0", seen, sat_count_c, sat_count);
        end
        wait_drain();
    endtask

    task automatic test_random();
        fork
            begin
                for (int i = 0; i < 24; i++)
                    send_beat(100 + i, $signed(12'($urandom)), $signed(12'($urandom)), int'($urandom_range(0, 3)));
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    ready_in = 1'($urandom_range(0, 1));
                    tick();
                end
                ready_in = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_reset_midstream();
        int stale = 0;
        ready_in = 1'b0;
        send_beat(80, 100, 200, 0);
        send_beat(81, 300, 400, 0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({valid_out, busy, tag_out, data_out, sat_flags, sat_count} !== '0) begin
            errors++;
            $display("FAIL reset_async: valid=%b busy=%b tag=%0d data=%h flags=%b count=%0d, required all 0",
                     valid_out, busy, tag_out, data_out, sat_flags, sat_count);
        end
        sb_q.delete();
        tick();
        tick();
        reset    = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (valid_out) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL stale_after_reset: got %0d valid cycles, required 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_bounds();
        test_back_to_back();
        test_counter_sat();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
